// File: rtl/truth_table_sweeper.sv
// Sweeps a combinational function through its full truth table, captures its
// output per vector into a result map, and compares that map against an expected map.
module truth_table_sweeper #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   expected,
   input  logic                 dut_s,
   output logic [N_IN-1:0]      dut_in,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   result,
   output logic                 pass,
   output logic                 fail_valid,
   output logic [N_IN-1:0]      first_fail
);

   localparam int N_VEC = 2**N_IN;
   localparam int CNT_W = ($clog2(SETTLE+1) > 1) ? $clog2(SETTLE+1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE-1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [N_IN-1:0]  IDX_ONE  = N_IN'(1);
   localparam logic [N_IN-1:0]  IDX_ZERO = {N_IN{1'b0}};
   localparam logic [N_IN-1:0]  IDX_LAST = {N_IN{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t              state_r, state_s;
   logic [N_IN-1:0]     idx_r, idx_s;
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic [N_VEC-1:0]    exp_r, exp_s;
   logic [N_IN-1:0]     dut_in_s;
   logic                busy_s;
   logic                done_s;
   logic [N_VEC-1:0]    result_s;
   logic                pass_s;
   logic                fail_valid_s;
   logic [N_IN-1:0]     first_fail_s;
   logic                mismatch_s;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and output registers; reset discards any partial sweep
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_r      <= IDX_ZERO;
         cnt_r      <= CNT_ZERO;
         exp_r      <= {N_VEC{1'b0}};
         dut_in     <= IDX_ZERO;
         busy       <= 1'b0;
         done       <= 1'b0;
         result     <= {N_VEC{1'b0}};
         pass       <= 1'b0;
         fail_valid <= 1'b0;
         first_fail <= IDX_ZERO;
      end else begin
         idx_r      <= idx_s;
         cnt_r      <= cnt_s;
         exp_r      <= exp_s;
         dut_in     <= dut_in_s;
         busy       <= busy_s;
         done       <= done_s;
         result     <= result_s;
         pass       <= pass_s;
         fail_valid <= fail_valid_s;
         first_fail <= first_fail_s;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_s      = state_r;
      idx_s        = idx_r;
      cnt_s        = cnt_r;
      exp_s        = exp_r;
      dut_in_s     = dut_in;
      busy_s       = busy;
      done_s       = 1'b0;
      result_s     = result;
      pass_s       = pass;
      fail_valid_s = fail_valid;
      first_fail_s = first_fail;
      mismatch_s   = 1'b0;

      case (state_r)
         S_IDLE: begin
            if (start) begin
               exp_s        = expected;
               idx_s        = IDX_ZERO;
               dut_in_s     = IDX_ZERO;
               result_s     = {N_VEC{1'b0}};
               fail_valid_s = 1'b0;
               pass_s       = 1'b0;
               cnt_s        = CNT_LOAD;
               busy_s       = 1'b1;
               state_s      = S_WAIT;
            end else begin
               busy_s  = 1'b0;
               state_s = S_IDLE;
            end
         end

         S_WAIT: begin
            if (cnt_r != CNT_ZERO) begin
               cnt_s   = cnt_r - CNT_ONE;
               state_s = S_WAIT;
            end else begin
               state_s = S_SAMPLE;
            end
         end

         S_SAMPLE: begin
            result_s[idx_r] = dut_s;
            mismatch_s      = (dut_s != exp_r[idx_r]);
            // Only the first mismatch is recorded, which is the lowest index
            if (mismatch_s && !fail_valid) begin
               first_fail_s = idx_r;
               fail_valid_s = 1'b1;
            end else begin
               first_fail_s = first_fail;
               fail_valid_s = fail_valid;
            end
            if (idx_r == IDX_LAST) begin
               // Compare against the map including the bit sampled this cycle
               pass_s  = (result_s == exp_r);
               done_s  = 1'b1;
               state_s = S_DONE;
            end else begin
               idx_s    = idx_r + IDX_ONE;
               dut_in_s = idx_r + IDX_ONE;
               cnt_s    = CNT_LOAD;
               state_s  = S_WAIT;
            end
         end

         S_DONE: begin
            busy_s  = 1'b0;
            state_s = S_IDLE;
         end

         default: begin
            busy_s  = 1'b0;
            state_s = S_IDLE;
         end
      endcase
   end

endmodule
